// File: rtl/cpu_fetch.sv
// cpu_fetch: LEGv8 instruction fetch stage.
// Owns the PC, runs a req/ready handshake with instruction memory, holds the
// fetched word for the decoder, takes branch redirects and stops on HALT.
module cpu_fetch #(
   parameter int unsigned             PC_WIDTH = 64,
   parameter logic [PC_WIDTH-1:0]     RESET_PC = '0
) (
   input  logic                clk,
   input  logic                reset,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_ready,
   input  logic [31:0]         imem_rdata,
   input  logic                stall,
   input  logic                take_branch,
   input  logic [PC_WIDTH-1:0] branch_target,
   output logic [31:0]         inst,
   output logic [PC_WIDTH-1:0] inst_pc,
   output logic                inst_valid,
   output logic [10:0]         inst31_21,
   output logic                halted
);

   localparam int unsigned INST_W  = 32;
   localparam int unsigned OP_W    = 11;
   localparam logic [OP_W-1:0] HALT_OP = 11'h7FF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      VALID = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t              r_state;
   logic [PC_WIDTH-1:0] r_pc;
   logic [INST_W-1:0]   r_inst;
   logic [PC_WIDTH-1:0] r_inst_pc;
   logic                r_inst_valid;
   logic                r_imem_req;
   logic                r_halted;

   state_t              w_state_nxt;
   logic [PC_WIDTH-1:0] w_pc_nxt;
   logic [INST_W-1:0]   w_inst_nxt;
   logic [PC_WIDTH-1:0] w_inst_pc_nxt;
   logic                w_inst_valid_nxt;
   logic                w_imem_req_nxt;
   logic                w_halted_nxt;
   logic                w_is_halt;

   assign w_is_halt = (r_inst[31:21] == HALT_OP);

   // Next-state and next-register values; a redirect overrides everything but HALT.
   always_comb begin
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_inst_nxt       = r_inst;
      w_inst_pc_nxt    = r_inst_pc;
      w_inst_valid_nxt = r_inst_valid;

      case (r_state)
         IDLE: begin
            w_state_nxt = FETCH;
         end
         FETCH: begin
            if (imem_ready) begin
               w_inst_nxt       = imem_rdata;
               w_inst_pc_nxt    = r_pc;
               w_pc_nxt         = r_pc + PC_WIDTH'(4);
               w_inst_valid_nxt = 1'b1;
               w_state_nxt      = VALID;
            end
         end
         VALID: begin
            if (!stall) begin
               w_inst_valid_nxt = 1'b0;
               w_state_nxt      = w_is_halt ? HALT : FETCH;
            end
         end
         HALT: begin
            w_inst_valid_nxt = 1'b0;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      // Redirect: drop any response or held word and restart at the aligned target.
      if (take_branch && (r_state != HALT)) begin
         w_pc_nxt         = {branch_target[PC_WIDTH-1:2], 2'b00};
         w_inst_nxt       = r_inst;
         w_inst_pc_nxt    = r_inst_pc;
         w_inst_valid_nxt = 1'b0;
         w_state_nxt      = FETCH;
      end

      w_imem_req_nxt = (w_state_nxt == FETCH);
      w_halted_nxt   = (w_state_nxt == HALT);
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_inst       <= '0;
         r_inst_pc    <= '0;
         r_inst_valid <= 1'b0;
         r_imem_req   <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_inst       <= w_inst_nxt;
         r_inst_pc    <= w_inst_pc_nxt;
         r_inst_valid <= w_inst_valid_nxt;
         r_imem_req   <= w_imem_req_nxt;
         r_halted     <= w_halted_nxt;
      end
   end

   assign imem_req   = r_imem_req;
   assign imem_addr  = r_pc;
   assign inst       = r_inst;
   assign inst_pc    = r_inst_pc;
   assign inst_valid = r_inst_valid;
   assign halted     = r_halted;
   assign inst31_21  = r_inst[31:21];

endmodule

// File: tb/tb_cpu_fetch.sv
// tb_cpu_fetch: directed-vector bench for cpu_fetch.
module tb_cpu_fetch;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        take_branch;
   logic [63:0] branch_target;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_valid;
   logic [10:0] inst31_21;
   logic        halted;

   int n_vec;
   int n_err;

   localparam logic [31:0] W0   = 32'h9100_0421;
   localparam logic [31:0] W1   = 32'hD100_0842;
   localparam logic [31:0] WADD = 32'h8B02_0020;
   localparam logic [31:0] W2   = 32'hB400_0040;
   localparam logic [31:0] WHLT = 32'hFFE0_0000;
   localparam logic [31:0] WBAD = 32'hDEAD_BEEF;

   cpu_fetch #(.PC_WIDTH(64), .RESET_PC(64'h0)) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .stall         (stall),
      .take_branch   (take_branch),
      .branch_target (branch_target),
      .inst          (inst),
      .inst_pc       (inst_pc),
      .inst_valid    (inst_valid),
      .inst31_21     (inst31_21),
      .halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expected value.
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_fetch(input string tag, input logic [63:0] addr);
      chk({tag, ".req"},   64'(imem_req), 64'd1);
      chk({tag, ".addr"},  imem_addr, addr);
      chk({tag, ".valid"}, 64'(inst_valid), 64'd0);
   endtask

   task automatic chk_valid(input string tag, input logic [31:0] w, input logic [63:0] pc);
      chk({tag, ".valid"}, 64'(inst_valid), 64'd1);
      chk({tag, ".req"},   64'(imem_req), 64'd0);
      chk({tag, ".inst"},  64'(inst), 64'(w));
      chk({tag, ".pc"},    inst_pc, pc);
      chk({tag, ".op"},    64'(inst31_21), 64'(w[31:21]));
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".req"},    64'(imem_req), 64'd0);
      chk({tag, ".addr"},   imem_addr, 64'h0);
      chk({tag, ".inst"},   64'(inst), 64'h0);
      chk({tag, ".pc"},     inst_pc, 64'h0);
      chk({tag, ".valid"},  64'(inst_valid), 64'd0);
      chk({tag, ".op"},     64'(inst31_21), 64'h0);
      chk({tag, ".halted"}, 64'(halted), 64'd0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b1;
      imem_ready = 1'b0;
      imem_rdata = '0;
      stall = 1'b0;
      take_branch = 1'b0;
      branch_target = '0;

      tick();
      tick();
      chk_reset("rst");

      // Sequential fetch; first request one cycle after release.
      reset = 1'b0;
      chk("idle.req", 64'(imem_req), 64'd0);
      tick();
      chk_fetch("f0", 64'h0);
      imem_ready = 1'b1; imem_rdata = W0;
      tick();
      chk_valid("v0", W0, 64'h0);
      chk("v0.next", imem_addr, 64'h4);

      // Wait states at 0x4.
      imem_ready = 1'b0;
      tick();
      chk_fetch("f4", 64'h4);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_fetch("ws", 64'h4);
      end
      imem_ready = 1'b1; imem_rdata = W1;
      tick();
      chk_valid("v4", W1, 64'h4);
      chk("v4.next", imem_addr, 64'h8);

      imem_ready = 1'b0;
      tick();
      chk_fetch("f8", 64'h8);
      imem_ready = 1'b1; imem_rdata = WADD;
      tick();
      chk_valid("v8", WADD, 64'h8);
      chk("v8.op", 64'(inst31_21), 64'h458);

      // Stall holds the ADD; memory data is ignored.
      stall = 1'b1; imem_rdata = WBAD;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_valid("stall", WADD, 64'h8);
         chk("stall.addr", imem_addr, 64'hC);
      end

      // Branch wins over stall; target bits [1:0] cleared.
      take_branch = 1'b1; branch_target = 64'h103;
      tick();
      chk_fetch("br", 64'h100);
      stall = 1'b0;

      // Branch in FETCH with a ready response discards the word.
      imem_ready = 1'b1; imem_rdata = WBAD; branch_target = 64'h200;
      tick();
      chk_fetch("brrdy", 64'h200);
      chk("brrdy.inst", 64'(inst), 64'(WADD));
      chk("brrdy.pc", inst_pc, 64'h8);
      take_branch = 1'b0; imem_rdata = W2;
      tick();
      chk_valid("v200", W2, 64'h200);

      // Stall then release: next fetch starts the cycle after.
      stall = 1'b1; imem_ready = 1'b0;
      tick();
      tick();
      chk_valid("st2", W2, 64'h200);
      stall = 1'b0;
      tick();
      chk_fetch("f204", 64'h204);

      // Flushed HALT does not halt.
      imem_ready = 1'b1; imem_rdata = WHLT;
      tick();
      chk_valid("vh0", WHLT, 64'h204);
      chk("vh0.op", 64'(inst31_21), 64'h7FF);
      imem_ready = 1'b0; take_branch = 1'b1; branch_target = 64'h300;
      tick();
      chk_fetch("flush", 64'h300);
      chk("flush.halted", 64'(halted), 64'd0);

      // Consumed HALT stops fetch permanently.
      take_branch = 1'b0; imem_ready = 1'b1; imem_rdata = WHLT;
      tick();
      chk_valid("vh1", WHLT, 64'h300);
      imem_ready = 1'b0;
      tick();
      chk("halt.halted", 64'(halted), 64'd1);
      chk("halt.valid", 64'(inst_valid), 64'd0);
      chk("halt.req", 64'(imem_req), 64'd0);
      for (int i = 0; i < 20; i++) begin
         take_branch = i[0]; branch_target = 64'h500; imem_ready = 1'b1;
         tick();
         chk("hold.req", 64'(imem_req), 64'd0);
         chk("hold.halted", 64'(halted), 64'd1);
         chk("hold.addr", imem_addr, 64'h304);
      end

      // Reset clears HALT asynchronously.
      take_branch = 1'b0; imem_ready = 1'b0;
      reset = 1'b1;
      #1;
      chk_reset("rst2");
      tick();
      reset = 1'b0;
      tick();
      chk_fetch("f0b", 64'h0);

      // PC increment wraps at the top of the address space.
      take_branch = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFE;
      tick();
      chk_fetch("wrapbr", 64'hFFFF_FFFF_FFFF_FFFC);
      take_branch = 1'b0; imem_ready = 1'b1; imem_rdata = W0;
      tick();
      chk_valid("wrapv", W0, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap.addr", imem_addr, 64'h0);
      imem_ready = 1'b0;
      tick();
      chk_fetch("wrapf", 64'h0);

      // Walk to FETCH at 0xC, then reset mid-request.
      imem_ready = 1'b1; imem_rdata = W0; tick();
      imem_ready = 1'b0; tick();
      imem_ready = 1'b1; imem_rdata = W1; tick();
      imem_ready = 1'b0; tick();
      imem_ready = 1'b1; imem_rdata = W2; tick();
      chk_valid("v8b", W2, 64'h8);
      imem_ready = 1'b0; tick();
      chk_fetch("fC", 64'hC);
      reset = 1'b1;
      #1;
      chk_reset("rst3");
      tick();
      chk("rst3.hold", 64'(imem_req), 64'd0);
      reset = 1'b0;
      tick();
      chk_fetch("f0c", 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
